mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
Sequencer that drives the 3-bit select of the 6:1 4-bit data mux stage (case_select) directly upstream of it. It steps sel round-robin over a programmable mask of enabled channels. Each channel is held for a programmable dwell time. Downstream logic samples the mux output while sel_valid is high; wrap marks the start of each new scan pass.

Parameters:
NUM_CH, 6, number of mux data inputs; constraint NUM_CH <= 2**SEL_W
SEL_W, 3, select width; must match the mux select port
DWELL_W, 4, width of the dwell count

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin scanning; accepted in IDLE only
stop  input  1  end scanning; accepted in DWELL
en_mask  input  NUM_CH  channel enable; bit i enables sel value i
dwell  input  DWELL_W  cycles per channel minus one (0 means 1 cycle)
sel  output  SEL_W  select to the mux, registered
sel_valid  output  1  high while sel addresses a channel being scanned
busy  output  1  high in DWELL state
wrap  output  1  one-cycle pulse when sel wraps to a lower or equal index
err  output  1  one-cycle pulse when the enabled set is empty at start or at an advance

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. On reset, asynchronously: state=IDLE, sel=0, sel_valid=0, busy=0, wrap=0, err=0, cnt=0.
- All outputs are registered. Every input is sampled on the rising edge of clk.
- States are IDLE and DWELL.
- IDLE, start=1 and en_mask!=0:
  - Next cycle: state=DWELL, sel=lowest set bit of en_mask, cnt=dwell, sel_valid=1, busy=1.
  - wrap is not asserted.
- IDLE, start=1 and en_mask==0: stay in IDLE; err pulses for 1 cycle; sel is unchanged.
- IDLE, start=0: sel holds its last value; sel_valid=0.
- DWELL, stop=1: next cycle state=IDLE, sel_valid=0, busy=0. sel holds. stop has priority over advance and start.
- DWELL, stop=0, cnt!=0: cnt decrements by 1.
- DWELL, stop=0, cnt==0 (advance):
  - Find the next enabled index: scan circularly from sel+1 modulo NUM_CH through the current en_mask, including sel itself as the last candidate.
  - Load sel with that index and reload cnt from the current dwell.
  - wrap=1 in the same cycle the new sel appears if new index <= old sel.
  - If en_mask==0 at the advance: go to IDLE, sel_valid=0, err pulses, sel holds.
- Dwell timing: each channel presents sel for exactly dwell+1 cycles, with no gap cycles between channels. Example: dwell=2 means 3 cycles per channel.
- Single enabled channel: sel is constant; wrap pulses once every dwell+1 cycles.
- en_mask and dwell are re-sampled only at an advance. Changing them mid-dwell does not affect the current channel.
- sel never takes a value >= NUM_CH (6 and 7 are never produced when NUM_CH=6). en_mask bits beyond NUM_CH-1 do not exist.
- start while in DWELL is ignored. stop while in IDLE is ignored.
- Reset asserted mid-dwell returns the block to reset values immediately. After reset deassertion, the block stays in IDLE until the next start.

Decomposition:
- Package mux_seq_pkg holds:
  - the state enum (IDLE, DWELL)
  - default constants NUM_CH=6, SEL_W=3, DWELL_W=4
  - the sel_t typedef logic [SEL_W-1:0], shared with the mux stage
- One combinational sub-module, rr_next_finder:
  - Inputs: mask and current index.
  - Outputs: next circular enabled index, a found flag, and a wrapped flag.
  - The same sub-module, given current index NUM_CH-1, yields the lowest set bit used at start.

Test Plan:
- Reset mid-scan: assert rst asynchronously between clock edges -> sel=0, sel_valid=0, busy=0 immediately, without waiting for a clk edge.
- en_mask=6'b111111, dwell=0, start -> sel sequence 0,1,2,3,4,5,0,... with one value per cycle; wrap pulses in the cycle sel returns to 0; sel never shows 6 or 7; the mux out shows a,b,c,d,e,f in turn.
- en_mask=6'b100101, dwell=2, start -> sel is 0 for 3 cycles, then 2 for 3 cycles, then 5 for 3 cycles, then 0 again with wrap=1.
- en_mask=6'b001000, dwell=1, start -> sel=3 constant; wrap pulses every 2 cycles; sel_valid stays 1.
- en_mask=0 with start -> err pulses for 1 cycle, busy stays 0. Separately, while running, clear en_mask mid-dwell -> current channel completes its dwell, then err pulses and the block returns to IDLE.
- stop and start asserted together during DWELL -> next cycle busy=0 and sel_valid=0, and sel holds its last value.

Source files
------------

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and default sizing for the mux select sequencer and the mux stage it drives.
package mux_seq_pkg;

  localparam int unsigned NUM_CH  = 6;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 4;

  typedef enum logic [0:0] {
    StIdle,
    StDwell
  } state_e;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_CH-1:0]  mask_t;
  typedef logic [DWELL_W-1:0] dwell_t;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Control/status bundle between a scan controller (master) and the sequencer (slave).
interface mux_sel_sequencer_if;
  import mux_seq_pkg::*;

  logic   start;
  logic   stop;
  mask_t  en_mask;
  dwell_t dwell;
  sel_t   sel;
  logic   sel_valid;
  logic   busy;
  logic   wrap;
  logic   err;

  modport master (
    output start,
    output stop,
    output en_mask,
    output dwell,
    input  sel,
    input  sel_valid,
    input  busy,
    input  wrap,
    input  err
  );

  modport slave (
    input  start,
    input  stop,
    input  en_mask,
    input  dwell,
    output sel,
    output sel_valid,
    output busy,
    output wrap,
    output err
  );

endinterface

// File: rtl/mux_sel_sequencer_rr_next_finder.sv
// Circular search for the next enabled channel after cur; cur itself is the last candidate.
module rr_next_finder #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              found,
  output logic              wrapped
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      logic [SEL_W-1:0] cand;
      cand = SEL_W'((32'(cur) + k) % NUM_CH);
      if (mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrapped = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer: steps sel over enabled channels, holding each for dwell+1 cycles.
module mux_sel_sequencer #(
  parameter int unsigned NUM_CH  = mux_seq_pkg::NUM_CH,
  parameter int unsigned SEL_W   = mux_seq_pkg::SEL_W,
  parameter int unsigned DWELL_W = mux_seq_pkg::DWELL_W
) (
  input logic                clk,
  input logic                rst,
  mux_sel_sequencer_if.slave bus
);
  import mux_seq_pkg::*;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DWELL_W-1:0] cnt_q;
  logic               sel_valid_q;
  logic               busy_q;
  logic               wrap_q;
  logic               err_q;

  logic [SEL_W-1:0]   find_cur;
  logic [SEL_W-1:0]   find_nxt;
  logic               find_found;
  logic               find_wrapped;

  // From IDLE, searching after the top index yields the lowest enabled channel.
  assign find_cur = (state_q == StIdle) ? SEL_W'(NUM_CH - 1) : sel_q;

  rr_next_finder #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_finder (
    .mask    (bus.en_mask),
    .cur     (find_cur),
    .nxt     (find_nxt),
    .found   (find_found),
    .wrapped (find_wrapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cnt_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          if (bus.start) begin
            if (find_found) begin
              state_q     <= StDwell;
              sel_q       <= find_nxt;
              cnt_q       <= bus.dwell;
              sel_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StDwell: begin
          if (bus.stop) begin
            state_q     <= StIdle;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (find_found) begin
            sel_q  <= find_nxt;
            cnt_q  <= bus.dwell;
            wrap_q <= find_wrapped;
          end else begin
            // Mask emptied while scanning: abandon the pass, sel keeps its last value.
            state_q     <= StIdle;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with hand-computed expected sequences.
module tb_mux_sel_sequencer;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  mux_sel_sequencer_if bus ();

  mux_sel_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] s, input logic v, input logic b,
                           input logic w, input logic e);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(v));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    chk({tag, ".err"}, 32'(bus.err), 32'(e));
  endtask

  initial begin
    logic [2:0] seq_a [8];
    logic       wrp_a [8];
    logic [2:0] seq_b [10];
    logic       wrp_c [6];

    passed = 0;
    total  = 0;
    seq_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    wrp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    seq_b = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd0};
    wrp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.en_mask = '0;
    bus.dwell   = '0;
    #12;
    chk_state("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_state("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All channels, one cycle each.
    bus.en_mask = 6'b111111;
    bus.dwell   = 4'd0;
    bus.start   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      bus.start = 1'b0;
      chk($sformatf("all.sel[%0d]", i), 32'(bus.sel), 32'(seq_a[i]));
      chk($sformatf("all.wrap[%0d]", i), 32'(bus.wrap), 32'(wrp_a[i]));
      chk($sformatf("all.valid[%0d]", i), 32'(bus.sel_valid), 32'd1);
    end

    // stop and start together: stop wins, sel holds at 1.
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk_state("stop_start", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_state("idle_hold", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Sparse mask 100101, dwell 2 -> 3 cycles per channel.
    bus.en_mask = 6'b100101;
    bus.dwell   = 4'd2;
    bus.start   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.start = 1'b0;
      chk($sformatf("sparse.sel[%0d]", i), 32'(bus.sel), 32'(seq_b[i]));
      chk($sformatf("sparse.wrap[%0d]", i), 32'(bus.wrap), (i == 9) ? 32'd1 : 32'd0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_state("sparse_stop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single channel 3, dwell 1: wrap every 2 cycles.
    bus.en_mask = 6'b001000;
    bus.dwell   = 4'd1;
    bus.start   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.start = 1'b0;
      chk_state($sformatf("single[%0d]", i), 3'd3, 1'b1, 1'b1, wrp_c[i], 1'b0);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_state("single_stop", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Empty mask at start.
    bus.en_mask = '0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk_state("empty_start", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_state("empty_after", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mask cleared mid-dwell: current channel finishes, then err and back to IDLE.
    bus.en_mask = 6'b000011;
    bus.dwell   = 4'd1;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    chk_state("clr.start", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.en_mask = '0;
    step();
    chk_state("clr.dwell", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_state("clr.err", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_state("clr.idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while scanning.
    bus.en_mask = 6'b111111;
    bus.dwell   = 4'd0;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("arst.pre_sel", 32'(bus.sel), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_state("arst.now", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    step();
    chk_state("arst.idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
